// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI link state encoding and constants
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_HIGH,
    ST_LOW,
    ST_HOLD,
    ST_GAP
  } spi_host_state_t;

  localparam bit SPI_CPOL       = 1'b0;
  localparam bit SPI_CPHA       = 1'b0;
  localparam int SPI_WORD_W_DEF = 8;

endpackage

// File: rtl/spi_tick_gen.sv
// rtl/spi_tick_gen.sv - half-period counter, one-cycle tick every CLK_DIV enabled cycles
module spi_tick_gen #(
  parameter int CLK_DIV = 4,
  parameter int CNT_W   = $clog2(CLK_DIV)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             start,
  output logic             tick,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  assign tick = en && (count == LAST);

  // Cleared on every tick so each phase starts from zero; never wraps mid-phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (start || !en || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/spi_host.sv
// rtl/spi_host.sv - SPI mode-0 host, MSB first; SPI_HOST_BURST_EN keeps cs low across back-to-back words
module spi_host
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int WORD_W  = SPI_WORD_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              done,
  output logic              busy,
  output logic              spi_clk,
  output logic              mosi,
  output logic              cs
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(WORD_W + 1);
`ifdef SPI_HOST_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  generate
    if (CLK_DIV < 2) begin : g_bad_div
      $error("spi_host: CLK_DIV must be >= 2");
    end
    if (WORD_W < 1) begin : g_bad_word
      $error("spi_host: WORD_W must be >= 1");
    end
  endgenerate

  spi_host_state_t   state, next_state;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [BIT_W-1:0]  bit_cnt, bit_cnt_d;
  logic [CNT_W-1:0]  count;
  logic              tick, last_bit, idle_take, burst_take, active;
  logic              cs_d, spi_clk_d, mosi_d, done_d, busy_d, tx_ready_d;

  assign last_bit   = (bit_cnt == BIT_W'(1));
  assign idle_take  = (state == ST_IDLE) && tx_valid && tx_ready;
  assign burst_take = BURST && (state == ST_HIGH) && tick && last_bit && tx_valid && tx_ready;

  spi_tick_gen #(.CLK_DIV(CLK_DIV), .CNT_W(CNT_W)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state != ST_IDLE),
    .start (idle_take),
    .tick  (tick),
    .count (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // bit_cnt holds the bits still to clock out, including the one on mosi now.
  always_comb begin
    next_state = state;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt;
    case (state)
      ST_IDLE: if (idle_take) begin
        next_state = ST_SETUP;
        shift_d    = tx_data;
        bit_cnt_d  = BIT_W'(WORD_W);
      end
      ST_SETUP: if (tick) next_state = ST_HIGH;
      ST_HIGH: if (tick) begin
        if (!last_bit) begin
          next_state = ST_LOW;
          shift_d    = shift_q << 1;
          bit_cnt_d  = bit_cnt - 1'b1;
        end else if (burst_take) begin
          next_state = ST_LOW;
          shift_d    = tx_data;
          bit_cnt_d  = BIT_W'(WORD_W);
        end else begin
          next_state = ST_HOLD;
        end
      end
      ST_LOW:  if (tick) next_state = ST_HIGH;
      ST_HOLD: if (tick) next_state = ST_GAP;
      ST_GAP:  if (tick) next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Outputs are derived from the next state so every pin comes straight off a flop.
  always_comb begin
    active     = next_state inside {ST_SETUP, ST_HIGH, ST_LOW, ST_HOLD};
    cs_d       = !active;
    spi_clk_d  = (next_state == ST_HIGH);
    mosi_d     = active ? shift_d[WORD_W-1] : 1'b0;
    done_d     = ((state == ST_HOLD) && tick) || burst_take;
    busy_d     = (next_state != ST_IDLE);
    tx_ready_d = (next_state == ST_IDLE) ||
                 (BURST && (state == ST_HIGH) && last_bit && (count == CNT_W'(CLK_DIV - 2)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q  <= '0;
      bit_cnt  <= '0;
      cs       <= 1'b1;
      spi_clk  <= 1'b0;
      mosi     <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
      tx_ready <= 1'b1;
    end else begin
      shift_q  <= shift_d;
      bit_cnt  <= bit_cnt_d;
      cs       <= cs_d;
      spi_clk  <= spi_clk_d;
      mosi     <= mosi_d;
      done     <= done_d;
      busy     <= busy_d;
      tx_ready <= tx_ready_d;
    end
  end

endmodule

// File: tb/tb_spi_host.sv
// tb/tb_spi_host.sv - directed self-checking bench for spi_host (CLK_DIV=4, WORD_W=8)
module tb_spi_host;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, done, busy, spi_clk, mosi, cs;

  always #5 clk = ~clk;

  spi_host #(.CLK_DIV(4), .WORD_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .done     (done),
    .busy     (busy),
    .spi_clk  (spi_clk),
    .mosi     (mosi),
    .cs       (cs)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Measurements of the latest run; k=1 is the first negedge after the first handshake.
  int          m_cs_low, m_rises, m_done, m_done_at, m_ready_at;
  int          m_first_low, m_first_rise, m_gap_min;
  bit          m_timeout, m_cs_at1, m_busy_at1;
  logic [31:0] m_rx;

  task automatic run(input logic [7:0] first, input logic [7:0] second, input int words,
                     input int mid_k, input logic [7:0] mid_data);
    bit   pend, finished, prev_sclk, low_seen;
    int   n, k, high_run;
    m_cs_low = 0; m_rises = 0; m_done = 0; m_done_at = 0; m_ready_at = 0;
    m_first_low = 0; m_first_rise = 0; m_gap_min = 9999; m_timeout = 0;
    m_cs_at1 = 1'b1; m_busy_at1 = 1'b0; m_rx = '0;
    finished = 0; prev_sclk = 0; low_seen = 0; n = 0; k = 0; high_run = 0;
    for (int c = 0; c < 200 && !tx_ready; c++) @(negedge clk);
    if (!tx_ready) begin
      m_timeout = 1;
      return;
    end
    tx_data = first; tx_valid = 1'b1; pend = 1;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      if (pend) begin
        n++; pend = 0;
        if (n < words) tx_data = second;
        else           tx_valid = 1'b0;
      end
      k++;
      if (mid_k != 0 && k == mid_k) tx_data = mid_data;
      if (k == 1) begin m_cs_at1 = cs; m_busy_at1 = busy; end
      if (!cs) begin
        m_cs_low++;
        if (m_first_low == 0) m_first_low = k;
        if (low_seen && high_run > 0 && high_run < m_gap_min) m_gap_min = high_run;
        high_run = 0; low_seen = 1;
      end else if (low_seen) begin
        high_run++;
      end
      if (spi_clk && !prev_sclk) begin
        m_rises++;
        m_rx = {m_rx[30:0], mosi};
        if (m_first_rise == 0) m_first_rise = k;
      end
      prev_sclk = spi_clk;
      if (done) begin
        m_done++;
        if (m_done_at == 0) m_done_at = k;
      end
      if (m_done_at != 0 && m_ready_at == 0 && k > m_done_at && tx_ready) m_ready_at = k;
      if (tx_valid && tx_ready) pend = 1;
      if (n == words && m_done == words && tx_ready && !tx_valid) begin
        finished = 1;
        break;
      end
    end
    if (!finished) m_timeout = 1;
    tx_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (cs !== 1'b1) begin n_fail++; $display("FAIL reset_hold_cs got=%b exp=1", cs); end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (cs !== 1'b1) begin n_fail++; $display("FAIL reset_cs got=%b exp=1", cs); end
    n_checks++; if (spi_clk !== 1'b0) begin n_fail++; $display("FAIL reset_spi_clk got=%b exp=0", spi_clk); end
    n_checks++; if (mosi !== 1'b0) begin n_fail++; $display("FAIL reset_mosi got=%b exp=0", mosi); end
    n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_tx_ready got=%b exp=1", tx_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
  endtask

  task automatic test_single_word();
    run(8'hA5, 8'h00, 1, 0, 8'h00);
    n_checks++; if (m_timeout) begin n_fail++; $display("FAIL a5_timeout got=1 exp=0"); end
    n_checks++; if (m_cs_at1 !== 1'b0) begin n_fail++; $display("FAIL a5_cs_latency got=%b exp=0", m_cs_at1); end
    n_checks++; if (m_busy_at1 !== 1'b1) begin n_fail++; $display("FAIL a5_busy got=%b exp=1", m_busy_at1); end
    n_checks++; if (m_rx[7:0] !== 8'hA5) begin n_fail++; $display("FAIL a5_data got=%h exp=a5", m_rx[7:0]); end
    n_checks++; if (m_rises != 8) begin n_fail++; $display("FAIL a5_rises got=%0d exp=8", m_rises); end
    n_checks++; if (m_cs_low != 68) begin n_fail++; $display("FAIL a5_cs_low got=%0d exp=68", m_cs_low); end
    n_checks++; if (m_done != 1) begin n_fail++; $display("FAIL a5_done_count got=%0d exp=1", m_done); end
    n_checks++; if (m_done_at != 69) begin n_fail++; $display("FAIL a5_done_at got=%0d exp=69", m_done_at); end
    n_checks++; if (m_ready_at - m_done_at != 4) begin n_fail++; $display("FAIL a5_ready_after_done got=%0d exp=4", m_ready_at - m_done_at); end
    n_checks++; if (m_first_rise - m_first_low != 4) begin n_fail++; $display("FAIL a5_first_rise got=%0d exp=4", m_first_rise - m_first_low); end
  endtask

  task automatic test_loopback_selector();
    run(8'h30, 8'h00, 1, 0, 8'h00);
    n_checks++; if (m_rx[7:0] !== 8'h30) begin n_fail++; $display("FAIL lb_command got=%h exp=30", m_rx[7:0]); end
    n_checks++; if (m_rx[7:4] !== 4'h3) begin n_fail++; $display("FAIL lb_selector got=%h exp=3", m_rx[7:4]); end
    n_checks++; if (m_done != 1) begin n_fail++; $display("FAIL lb_done_count got=%0d exp=1", m_done); end
  endtask

  task automatic test_back_to_back();
    run(8'h12, 8'h34, 2, 0, 8'h00);
    n_checks++; if (m_timeout) begin n_fail++; $display("FAIL b2b_timeout got=1 exp=0"); end
    n_checks++; if (m_rx[15:0] !== 16'h1234) begin n_fail++; $display("FAIL b2b_data got=%h exp=1234", m_rx[15:0]); end
    n_checks++; if (m_rises != 16) begin n_fail++; $display("FAIL b2b_rises got=%0d exp=16", m_rises); end
    n_checks++; if (m_done != 2) begin n_fail++; $display("FAIL b2b_done_count got=%0d exp=2", m_done); end
`ifdef SPI_HOST_BURST_EN
    n_checks++; if (m_gap_min != 9999) begin n_fail++; $display("FAIL b2b_cs_gap got=%0d exp=none", m_gap_min); end
    n_checks++; if (m_cs_low != 132) begin n_fail++; $display("FAIL b2b_cs_low got=%0d exp=132", m_cs_low); end
`else
    n_checks++; if (m_gap_min != 5) begin n_fail++; $display("FAIL b2b_cs_gap got=%0d exp=5", m_gap_min); end
    n_checks++; if (m_cs_low != 136) begin n_fail++; $display("FAIL b2b_cs_low got=%0d exp=136", m_cs_low); end
`endif
  endtask

  task automatic test_async_reset();
    int  rises;
    bit  prev;
    rises = 0; prev = 0;
    for (int c = 0; c < 200 && !tx_ready; c++) @(negedge clk);
    tx_data = 8'h3C; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    for (int c = 0; c < 200 && rises < 3; c++) begin
      if (spi_clk && !prev) rises++;
      prev = spi_clk;
      if (rises < 3) @(negedge clk);
    end
    n_checks++; if (rises != 3) begin n_fail++; $display("FAIL ar_third_rise got=%0d exp=3", rises); end
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (cs !== 1'b1) begin n_fail++; $display("FAIL ar_cs got=%b exp=1", cs); end
    n_checks++; if (spi_clk !== 1'b0) begin n_fail++; $display("FAIL ar_spi_clk got=%b exp=0", spi_clk); end
    n_checks++; if (mosi !== 1'b0) begin n_fail++; $display("FAIL ar_mosi got=%b exp=0", mosi); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ar_busy got=%b exp=0", busy); end
    n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL ar_tx_ready got=%b exp=1", tx_ready); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run(8'hFF, 8'h00, 1, 0, 8'h00);
    n_checks++; if (m_rx[7:0] !== 8'hFF) begin n_fail++; $display("FAIL ar_after_data got=%h exp=ff", m_rx[7:0]); end
    n_checks++; if (m_rises != 8) begin n_fail++; $display("FAIL ar_after_rises got=%0d exp=8", m_rises); end
    n_checks++; if (m_cs_low != 68) begin n_fail++; $display("FAIL ar_after_cs_low got=%0d exp=68", m_cs_low); end
  endtask

  task automatic test_data_change();
    int lows;
    lows = 0;
    run(8'h5A, 8'h00, 1, 20, 8'hC3);
    n_checks++; if (m_rx[7:0] !== 8'h5A) begin n_fail++; $display("FAIL dc_first got=%h exp=5a", m_rx[7:0]); end
    repeat (20) begin
      @(negedge clk);
      if (!cs) lows++;
    end
    n_checks++; if (lows != 0) begin n_fail++; $display("FAIL dc_no_handshake_cs_low got=%0d exp=0", lows); end
    run(8'hC3, 8'h00, 1, 0, 8'h00);
    n_checks++; if (m_rx[7:0] !== 8'hC3) begin n_fail++; $display("FAIL dc_second got=%h exp=c3", m_rx[7:0]); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_loopback_selector();
    test_back_to_back();
    test_async_reset();
    test_data_change();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_host.md
# spi_host

Clock-divided SPI mode-0 host: serialises one command word per handshake onto `spi_clk`/`mosi`/`cs`, MSB first. It is the transmitting end of the `spi_client` link that drives waveform selection. The upper nibble of an 8-bit command is the waveform selector. It sits on the controller-side FPGA, or in a loopback bench, driven by a command source through a valid/ready handshake.

## Interface
Parameters:
- `CLK_DIV`, 4: `clk` cycles per SPI half-period; must be ≥ 2 (elaboration `$error` otherwise).
- `WORD_W`, 8: bits per word; must be ≥ 1.

Ports:
- `clk` input 1: system clock; the only clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `tx_data` input `WORD_W`: word to send; captured at handshake.
- `tx_valid` input 1: source has a word.
- `tx_ready` output 1: host accepts a word this cycle.
- `done` output 1: one-cycle pulse when a word has been fully shifted out.
- `busy` output 1: high from the cycle after a handshake until return to IDLE.
- `spi_clk` output 1: SPI clock, CPOL=0.
- `mosi` output 1: serial data; changes only while `spi_clk`=0.
- `cs` output 1: chip select, active-low.

## Operation
- States: IDLE, SETUP, HIGH, LOW, HOLD, GAP.
- Reset values: `cs`=1, `spi_clk`=0, `mosi`=0, `tx_ready`=1, `done`=0, `busy`=0, state IDLE, shift register 0.
- IDLE: `tx_ready`=1. On `tx_valid && tx_ready`: load `tx_data` into the shift register and go to SETUP.
- SETUP, `CLK_DIV` cycles: `cs`=0, `mosi`=MSB, `spi_clk`=0. Then go to HIGH.
- HIGH, `CLK_DIV` cycles: `spi_clk`=1; the client samples on the rising edge. At the end of the phase, if bits remain, go to LOW; otherwise go to HOLD.
- LOW, `CLK_DIV` cycles: `spi_clk`=0. On the first cycle, shift left; `mosi` = next bit. Then go to HIGH.
- HOLD, `CLK_DIV` cycles: `spi_clk`=0, `cs`=0. On exit: `cs`=1, `done`=1 for one cycle, go to GAP.
- GAP, `CLK_DIV` cycles: `cs`=1. Then go to IDLE.
- Bit counter: `$clog2(WORD_W+1)` bits. Phase counter: `$clog2(CLK_DIV)` bits, reloads each phase, never wraps mid-phase.
- `tx_data` changes after the handshake are ignored. `tx_valid` held during a transfer is not accepted until IDLE.
- `rst_n` low at any point, including mid-word: all outputs return to reset values immediately, without waiting for a clock edge. No partial word resumes.
- Exactly `WORD_W` rising edges of `spi_clk` occur per word; no glitch on `spi_clk` or `cs`.

## Timing
- Handshake to `cs` falling: 1 cycle, registered.
- `cs` low duration: (2·`WORD_W`+1)·`CLK_DIV` cycles; 68 for the defaults.
- First `spi_clk` rise: `CLK_DIV` cycles after `cs` falls.
- `done` asserts in the same cycle `cs` rises.
- `tx_ready` re-asserts `CLK_DIV` cycles after `done`.
- Minimum word-to-word period (non-burst): (2·`WORD_W`+2)·`CLK_DIV`+1 cycles.
- All outputs are registered.

## Configuration
Macro: `SPI_HOST_BURST_EN`.
- Defined:
  - `tx_ready` is also high in the final cycle of the last HIGH phase.
  - A handshake there loads the new word and pulses `done` for the finished word.
  - The host goes to LOW with `mosi` = new MSB and `cs` held low; no HOLD/GAP between burst words.
  - HOLD/GAP occur only after the final word.
- Undefined: `cs` deasserts and GAP runs between every word, as described in Operation.

## Structure
- `spi_pkg`: state enum `spi_host_state_t`, constants `SPI_CPOL`=0, `SPI_CPHA`=0, `SPI_WORD_W_DEF`=8. Shared with `spi_client`.
- One sub-module, `spi_tick_gen`: half-period counter that emits a one-cycle `tick` every `CLK_DIV` cycles and restarts on `start`. The FSM and shift register stay in `spi_host`.

## Test plan
Defaults `CLK_DIV`=4, `WORD_W`=8.
- Reset: hold `rst_n`=0, then release → `cs`=1, `spi_clk`=0, `mosi`=0, `tx_ready`=1, `busy`=0, `done`=0.
- Send 0xA5 → bits on rising edges 1,0,1,0,0,1,0,1; 8 rising edges; `cs` low 68 cycles; one `done`; `tx_ready` high 4 cycles after `done`.
- Loopback into `spi_client`, send 0x30 → client `command`=0x30, one `command_signal`, selector=3.
- Back-to-back 0x12 then 0x34 with `tx_valid` held:
  - Without macro: `cs` high ≥4 cycles between words.
  - With `SPI_HOST_BURST_EN`: `cs` low continuously, 16 rising edges, two `done` pulses.
- `rst_n` pulled low asynchronously after the 3rd rising edge → `cs`=1 and `spi_clk`=0 before the next `clk` edge. A following 0xFF is sent intact (8 ones).
- Change `tx_data` from 0x5A to 0xC3 mid-word → receiver sees 0x5A; 0xC3 is sent only after a new handshake.
